obuf_access_arbiter: RTL and testbench

//  Cycle-level arbiter for the single-port output-buffer SRAM (1-cycle read latency).

---
 rtl/obuf_access_arbiter.sv | 138 +++++++++++++
 tb/tb_obuf_access_arbiter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/obuf_access_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : obuf_access_arbiter
// Brief   : Shares the single-port output-buffer SRAM between the EPU datapath
//           and the host port, with bounded host starvation during layer runs.
// Revision: 1.0 - initial release
// ============================================================================
module obuf_access_arbiter #(
    parameter int ADDR_W     = 14,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              epu_start_i,
    input  logic              epu_done_i,
    input  logic              epu_req_i,
    input  logic              epu_we_i,
    input  logic [ADDR_W-1:0] epu_addr_i,
    input  logic [DATA_W-1:0] epu_wdata_i,
    output logic              epu_gnt_o,
    output logic              epu_rvalid_o,
    input  logic              host_req_i,
    input  logic              host_we_i,
    input  logic [ADDR_W-1:0] host_addr_i,
    input  logic [DATA_W-1:0] host_wdata_i,
    output logic              host_gnt_o,
    output logic              host_rvalid_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic              sram_cs_o,
    output logic              sram_oe_o,
    output logic              sram_we_o,
    output logic [ADDR_W-1:0] sram_addr_o,
    output logic [DATA_W-1:0] sram_wdata_o,
    input  logic [DATA_W-1:0] sram_rdata_i,
    output logic              epu_mode_o
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {
        ST_HOST_RUN = 2'd0,
        ST_EPU_RUN  = 2'd1,
        ST_DRAIN    = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] starve_q, starve_d;
    logic             epu_rd_q, host_rd_q;
    logic             epu_gnt, host_gnt, force_host;

    // Grants are masked by rst so the SRAM goes idle the moment reset asserts.
    always_comb begin
        epu_gnt    = 1'b0;
        host_gnt   = 1'b0;
        force_host = 1'b0;
        if (!rst) begin
            if (state_q == ST_HOST_RUN) begin
                host_gnt = host_req_i;
                epu_gnt  = epu_req_i & ~host_req_i;
            end else begin
                force_host = host_req_i && (starve_q == CNT_W'(STARVE_MAX));
                host_gnt   = host_req_i & (~epu_req_i | force_host);
                epu_gnt    = epu_req_i & ~host_gnt;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        starve_d = starve_q;
        if (host_gnt) begin
            starve_d = '0;
        end else if (epu_gnt && host_req_i && (state_q != ST_HOST_RUN)) begin
            starve_d = starve_q + CNT_W'(1);
        end
        case (state_q)
            ST_HOST_RUN: begin
                if (epu_start_i) begin
                    state_d  = ST_EPU_RUN;
                    starve_d = '0;
                end
            end
            ST_EPU_RUN: begin
                if (epu_done_i) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (epu_start_i) begin
                    state_d  = ST_EPU_RUN;
                    starve_d = '0;
                end else begin
                    state_d = ST_HOST_RUN;
                end
            end
            default: state_d = ST_HOST_RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_HOST_RUN;
            starve_q  <= '0;
            epu_rd_q  <= 1'b0;
            host_rd_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            starve_q  <= starve_d;
            epu_rd_q  <= epu_gnt & ~epu_we_i;
            host_rd_q <= host_gnt & ~host_we_i;
        end
    end

    always_comb begin
        sram_cs_o    = epu_gnt | host_gnt;
        sram_we_o    = (epu_gnt & epu_we_i) | (host_gnt & host_we_i);
        sram_oe_o    = sram_cs_o & ~sram_we_o;
        sram_addr_o  = '0;
        sram_wdata_o = '0;
        if (host_gnt) begin
            sram_addr_o  = host_addr_i;
            sram_wdata_o = host_wdata_i;
        end else if (epu_gnt) begin
            sram_addr_o  = epu_addr_i;
            sram_wdata_o = epu_wdata_i;
        end
    end

    assign epu_gnt_o     = epu_gnt;
    assign host_gnt_o    = host_gnt;
    assign epu_rvalid_o  = epu_rd_q;
    assign host_rvalid_o = host_rd_q;
    assign rdata_o       = (epu_rd_q | host_rd_q) ? sram_rdata_i : '0;
    assign epu_mode_o    = (state_q != ST_HOST_RUN);

endmodule
`default_nettype wire

// File: tb/tb_obuf_access_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_obuf_access_arbiter
// Brief   : Self-checking bench for obuf_access_arbiter with an SRAM model and
//           a transaction-level reference of the arbitration rules.
// Revision: 1.0 - initial release
// ============================================================================
module tb_obuf_access_arbiter;

    localparam int ADDR_W     = 14;
    localparam int DATA_W     = 32;
    localparam int STARVE_MAX = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              epu_start_i, epu_done_i, epu_req_i, epu_we_i;
    logic [ADDR_W-1:0] epu_addr_i;
    logic [DATA_W-1:0] epu_wdata_i;
    logic              epu_gnt_o, epu_rvalid_o;
    logic              host_req_i, host_we_i;
    logic [ADDR_W-1:0] host_addr_i;
    logic [DATA_W-1:0] host_wdata_i;
    logic              host_gnt_o, host_rvalid_o;
    logic [DATA_W-1:0] rdata_o;
    logic              sram_cs_o, sram_oe_o, sram_we_o;
    logic [ADDR_W-1:0] sram_addr_o;
    logic [DATA_W-1:0] sram_wdata_o;
    logic [DATA_W-1:0] sram_rdata_i;
    logic              epu_mode_o;

    obuf_access_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk(clk), .rst(rst),
        .epu_start_i(epu_start_i), .epu_done_i(epu_done_i),
        .epu_req_i(epu_req_i), .epu_we_i(epu_we_i),
        .epu_addr_i(epu_addr_i), .epu_wdata_i(epu_wdata_i),
        .epu_gnt_o(epu_gnt_o), .epu_rvalid_o(epu_rvalid_o),
        .host_req_i(host_req_i), .host_we_i(host_we_i),
        .host_addr_i(host_addr_i), .host_wdata_i(host_wdata_i),
        .host_gnt_o(host_gnt_o), .host_rvalid_o(host_rvalid_o),
        .rdata_o(rdata_o),
        .sram_cs_o(sram_cs_o), .sram_oe_o(sram_oe_o), .sram_we_o(sram_we_o),
        .sram_addr_o(sram_addr_o), .sram_wdata_o(sram_wdata_o),
        .sram_rdata_i(sram_rdata_i),
        .epu_mode_o(epu_mode_o)
    );

    always #5 clk = ~clk;

    // SRAM macro model: 1-cycle read latency, unwritten words read as zero.
    logic [DATA_W-1:0] sram_mem [int];
    always @(posedge clk) begin
        if (sram_cs_o) begin
            if (sram_we_o) sram_mem[int'(sram_addr_o)] = sram_wdata_o;
            else sram_rdata_i <= sram_mem.exists(int'(sram_addr_o)) ? sram_mem[int'(sram_addr_o)] : '0;
        end
    end

    int vectors    = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: run mode, starvation tally, outstanding read and memory image.
    localparam int M_HOST = 0, M_EPU = 1, M_DRAIN = 2;
    int                m_mode, m_starve, m_pend;
    logic [ADDR_W-1:0] m_pend_addr;
    logic [DATA_W-1:0] m_mem [int];

    logic              obs_egnt, obs_hgnt, obs_erv, obs_hrv, obs_mode;
    logic [DATA_W-1:0] obs_rdata;

    function automatic logic [DATA_W-1:0] mget(input logic [ADDR_W-1:0] a);
        return m_mem.exists(int'(a)) ? m_mem[int'(a)] : '0;
    endfunction

    task automatic model_reset();
        m_mode = M_HOST; m_starve = 0; m_pend = 0; m_pend_addr = '0;
    endtask

    task automatic cyc(input logic st, input logic dn,
                       input logic er, input logic ew, input logic [ADDR_W-1:0] ea, input logic [DATA_W-1:0] ed,
                       input logic hr, input logic hw, input logic [ADDR_W-1:0] ha, input logic [DATA_W-1:0] hd);
        int                w;
        logic              wwe;
        logic [ADDR_W-1:0] wa;
        logic [DATA_W-1:0] wd;
        @(negedge clk);
        epu_start_i = st; epu_done_i = dn;
        epu_req_i = er; epu_we_i = ew; epu_addr_i = ea; epu_wdata_i = ed;
        host_req_i = hr; host_we_i = hw; host_addr_i = ha; host_wdata_i = hd;
        #1;
        // Winner: host priority between runs; EPU priority in a run unless the host has waited STARVE_MAX grants.
        w = 0;
        if (m_mode == M_HOST) w = hr ? 2 : (er ? 1 : 0);
        else if (hr && (!er || m_starve == STARVE_MAX)) w = 2;
        else if (er) w = 1;
        wwe = (w == 1) ? ew : hw;
        wa  = (w == 1) ? ea : ((w == 2) ? ha : '0);
        wd  = (w == 1) ? ed : ((w == 2) ? hd : '0);
        chk("gnt", {epu_gnt_o, host_gnt_o}, {w == 1, w == 2});
        chk("sram_ctl", {sram_cs_o, sram_oe_o, sram_we_o},
            {w != 0, (w != 0) && !wwe, (w != 0) && wwe});
        chk("sram_addr_wdata", {sram_addr_o, sram_wdata_o}, {wa, wd});
        chk("rvalid", {epu_rvalid_o, host_rvalid_o}, {m_pend == 1, m_pend == 2});
        chk("rdata", rdata_o, (m_pend != 0) ? mget(m_pend_addr) : '0);
        chk("mode", epu_mode_o, m_mode != M_HOST);
        obs_egnt = epu_gnt_o; obs_hgnt = host_gnt_o; obs_erv = epu_rvalid_o;
        obs_hrv = host_rvalid_o; obs_rdata = rdata_o; obs_mode = epu_mode_o;
        // advance model to the next cycle
        if (w != 0 && wwe) m_mem[int'(wa)] = wd;
        m_pend = (w != 0 && !wwe) ? w : 0;
        m_pend_addr = wa;
        if (w == 2) m_starve = 0;
        else if (w == 1 && hr && m_mode != M_HOST) m_starve++;
        case (m_mode)
            M_HOST:  if (st) begin m_mode = M_EPU; m_starve = 0; end
            M_EPU:   if (dn) m_mode = M_DRAIN;
            default: if (st) begin m_mode = M_EPU; m_starve = 0; end else m_mode = M_HOST;
        endcase
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, '0, '0, 0, 0, '0, '0);
    endtask

    typedef struct {
        logic st, dn, er, ew;
        logic [ADDR_W-1:0] ea;
        logic [DATA_W-1:0] ed;
        logic hr, hw;
        logic [ADDR_W-1:0] ha;
        logic [DATA_W-1:0] hd;
        logic [1:0] exp_gnt;   // {epu, host}
        logic exp_mode;
    } vec_t;

    vec_t tbl [9];
    int   hidx;

    initial begin
        tbl[0] = '{0, 0, 0, 0, 14'h000, 32'h0,        1, 1, 14'h010, 32'h12345678, 2'b01, 0};
        tbl[1] = '{0, 0, 1, 1, 14'h020, 32'hCAFE0020, 1, 0, 14'h010, 32'h0,        2'b01, 0};
        tbl[2] = '{0, 0, 1, 1, 14'h020, 32'hCAFE0020, 0, 0, 14'h000, 32'h0,        2'b10, 0};
        tbl[3] = '{1, 1, 1, 0, 14'h020, 32'h0,        1, 0, 14'h020, 32'h0,        2'b01, 0};
        tbl[4] = '{0, 0, 0, 0, 14'h000, 32'h0,        1, 0, 14'h020, 32'h0,        2'b01, 1};
        tbl[5] = '{0, 0, 1, 0, 14'h020, 32'h0,        1, 0, 14'h010, 32'h0,        2'b10, 1};
        tbl[6] = '{1, 1, 1, 1, 14'h021, 32'h00000055, 1, 1, 14'h011, 32'h0000AA11, 2'b10, 1};
        tbl[7] = '{0, 0, 0, 0, 14'h000, 32'h0,        1, 1, 14'h011, 32'h0000AA11, 2'b01, 1};
        tbl[8] = '{0, 0, 0, 0, 14'h000, 32'h0,        0, 0, 14'h000, 32'h0,        2'b00, 0};

        // Reset state, with a host request already pending to prove grants are masked.
        rst = 1'b1;
        epu_start_i = 0; epu_done_i = 0; epu_req_i = 0; epu_we_i = 0;
        epu_addr_i = '0; epu_wdata_i = '0;
        host_req_i = 1; host_we_i = 0; host_addr_i = 14'h5; host_wdata_i = '0;
        model_reset();
        #3;
        chk("rst_outputs", {epu_gnt_o, host_gnt_o, sram_cs_o, epu_rvalid_o, host_rvalid_o, epu_mode_o, rdata_o},
            '0);
        @(negedge clk);
        host_req_i = 0;
        rst = 1'b0;

        // Reset asserted mid-read while in a run.
        cyc(1, 0, 0, 0, '0, '0, 0, 0, '0, '0);
        cyc(0, 0, 0, 0, '0, '0, 1, 0, 14'h005, '0);
        chk("pre_rst_hgnt", obs_hgnt, 1'b1);
        @(posedge clk);
        #1;
        chk("pre_rst_rvalid_mode", {host_rvalid_o, epu_mode_o}, 2'b11);
        rst = 1'b1;
        #1;
        chk("async_rst", {host_rvalid_o, host_gnt_o, sram_cs_o, epu_mode_o}, 4'b0000);
        @(negedge clk);
        host_req_i = 0;
        rst = 1'b0;
        model_reset();

        for (int i = 0; i < 9; i++) begin
            cyc(tbl[i].st, tbl[i].dn, tbl[i].er, tbl[i].ew, tbl[i].ea, tbl[i].ed,
                tbl[i].hr, tbl[i].hw, tbl[i].ha, tbl[i].hd);
            chk($sformatf("tbl%0d_gnt", i), {obs_egnt, obs_hgnt}, tbl[i].exp_gnt);
            chk($sformatf("tbl%0d_mode", i), obs_mode, tbl[i].exp_mode);
            if (i == 2) chk("tbl2_host_rdata", {obs_hrv, obs_rdata}, {1'b1, 32'h12345678});
        end

        // EPU write to the top word, then host readback.
        cyc(0, 0, 1, 1, 14'h3FFF, 32'hDEADBEEF, 0, 0, '0, '0);
        chk("t4_egnt", obs_egnt, 1'b1);
        cyc(0, 0, 0, 0, '0, '0, 1, 0, 14'h3FFF, '0);
        chk("t4_hgnt", obs_hgnt, 1'b1);
        idle();
        chk("t4_readback", {obs_hrv, obs_rdata}, {1'b1, 32'hDEADBEEF});

        // EPU read granted in the done cycle returns in DRAIN.
        cyc(1, 0, 0, 0, '0, '0, 0, 0, '0, '0);
        cyc(0, 1, 1, 0, 14'h3FFF, '0, 0, 0, '0, '0);
        chk("t5_egnt", {obs_egnt, obs_mode}, 2'b11);
        idle();
        chk("t5_drain_rv", {obs_erv, obs_mode, obs_rdata}, {1'b1, 1'b1, 32'hDEADBEEF});
        idle();
        chk("t5_mode_fall", obs_mode, 1'b0);

        // Starvation bound: EPU and host both requesting continuously.
        cyc(1, 0, 0, 0, '0, '0, 0, 0, '0, '0);
        hidx = 0;
        for (int k = 0; k < 27; k++) begin
            cyc(0, 0, 1, 1, 14'(14'h100 + k), 32'(k), 1, 0, 14'(14'h040 + hidx), '0);
            chk($sformatf("starve_gnt%0d", k), {obs_egnt, obs_hgnt}, (k % 9 == 8) ? 2'b01 : 2'b10);
            chk($sformatf("starve_rv%0d", k), obs_hrv, (k > 0) && ((k - 1) % 9 == 8));
            if (obs_hgnt) hidx++;
        end
        cyc(0, 1, 0, 0, '0, '0, 0, 0, '0, '0);
        chk("starve_last_rv", obs_hrv, 1'b1);
        idle();
        idle();

        // Randomized traffic against the reference model.
        for (int n = 0; n < 1500; n++) begin
            cyc($urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0,
                $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                14'($urandom_range(0, 15)), $urandom,
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                14'($urandom_range(0, 15)), $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
